// File: rtl/rps_pkg.sv
// ---------------------------------------------------------------------------
// rps_pkg
// Shared encodings for the rock-paper-scissors match controller:
//   - player move codes (2 bits, 11 = invalid / no move)
//   - round / match winner codes (2 bits)
//   - FSM state encoding of the match controller
// A small helper function captures the "which move beats which" rule so the
// judge logic reads as a plain rule list.
// ---------------------------------------------------------------------------
package rps_pkg;

    // Player move encodings
    localparam logic [1:0] MOVE_ROCK     = 2'b00;
    localparam logic [1:0] MOVE_PAPER    = 2'b01;
    localparam logic [1:0] MOVE_SCISSORS = 2'b10;
    localparam logic [1:0] MOVE_INVALID  = 2'b11;

    // Winner encodings, shared by round_winner and match_winner
    localparam logic [1:0] WIN_TIE  = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_NONE = 2'b00;

    // Match controller FSM states; the three unused codes fall back to IDLE
    typedef enum logic [2:0] {
        ST_IDLE       = 3'b000,
        ST_COLLECT    = 3'b001,
        ST_JUDGE      = 3'b010,
        ST_REPORT     = 3'b011,
        ST_MATCH_OVER = 3'b100
    } state_t;

    // True when move a defeats move b. Both moves must be legal (not 11).
    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return ((a == MOVE_ROCK)     && (b == MOVE_SCISSORS)) ||
               ((a == MOVE_PAPER)    && (b == MOVE_ROCK))     ||
               ((a == MOVE_SCISSORS) && (b == MOVE_PAPER));
    endfunction

endpackage

// File: rtl/rps_judge.sv
// ---------------------------------------------------------------------------
// rps_judge
// Purely combinational round resolution.
// Ports:
//   p1_move  in  2  player 1 move (00 rock, 01 paper, 10 scissors, 11 invalid)
//   p2_move  in  2  player 2 move
//   winner   out 2  00 tie, 01 player 1, 10 player 2
// Rules: equal moves tie (including two invalid moves); a single invalid
// move loses; otherwise the classic beats relation decides.
// ---------------------------------------------------------------------------
module rps_judge
    import rps_pkg::*;
(
    input  logic [1:0] p1_move,
    input  logic [1:0] p2_move,
    output logic [1:0] winner
);

    // NOTE: every signal written in an always_comb gets a default on entry so
    // no path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        winner = WIN_TIE;
        if (p1_move == p2_move) begin
            winner = WIN_TIE;
        end else if (p1_move == MOVE_INVALID) begin
            winner = WIN_P2;
        end else if (p2_move == MOVE_INVALID) begin
            winner = WIN_P1;
        end else if (beats(p1_move, p2_move)) begin
            winner = WIN_P1;
        end else begin
            winner = WIN_P2;
        end
    end

endmodule

// File: rtl/rps_match_controller.sv
// ---------------------------------------------------------------------------
// rps_match_controller
// Runs a rock-paper-scissors match between two players: collects one move
// from each player with a valid/ready handshake, judges the round, keeps the
// score and declares a match winner once a player reaches TARGET_WINS.
//
// Parameters:
//   TARGET_WINS     round wins that end a match (1..7)
//   TIMEOUT_CYCLES  cycles allowed in COLLECT before missing moves forfeit (1..255)
//
// Ports:
//   clk              in   1  rising-edge clock
//   reset            in   1  asynchronous, active-high reset
//   start            in   1  level: starts a match from IDLE, releases MATCH_OVER when low
//   abort            in   1  cancels the match in progress
//   p1_valid/p2_valid in  1  player move offered
//   p1_move/p2_move  in   2  offered move
//   p1_ready/p2_ready out 1  controller will capture that player's move
//   round_winner     out  2  result of the last judged round
//   round_done       out  1  one-cycle pulse per resolved round (REPORT state)
//   p1_score/p2_score out 3  round wins in the current match
//   round_count      out  8  resolved rounds including ties (saturating)
//   match_done       out  1  high in MATCH_OVER only
//   match_winner     out  2  01 P1, 10 P2, 00 while undecided
//   state            out  3  current FSM state
// ---------------------------------------------------------------------------
module rps_match_controller
    import rps_pkg::*;
#(
    parameter int TARGET_WINS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       p1_valid,
    input  logic       p2_valid,
    input  logic [1:0] p1_move,
    input  logic [1:0] p2_move,
    output logic       p1_ready,
    output logic       p2_ready,
    output logic [1:0] round_winner,
    output logic       round_done,
    output logic [2:0] p1_score,
    output logic [2:0] p2_score,
    output logic [7:0] round_count,
    output logic       match_done,
    output logic [1:0] match_winner,
    output logic [2:0] state
);

    localparam logic [2:0] TARGET     = 3'(TARGET_WINS);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Registered state and its next-state values
    state_t     state_q, state_d;
    logic       p1_captured_q, p1_captured_d;
    logic       p2_captured_q, p2_captured_d;
    logic [1:0] p1_move_q, p1_move_d;
    logic [1:0] p2_move_q, p2_move_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] p1_score_q, p1_score_d;
    logic [2:0] p2_score_q, p2_score_d;
    logic [7:0] round_count_q, round_count_d;
    logic [1:0] round_winner_q, round_winner_d;
    logic [1:0] match_winner_q, match_winner_d;

    logic       p1_capture;
    logic       p2_capture;
    logic [1:0] p1_effective;
    logic [1:0] p2_effective;
    logic [1:0] judge_winner;

    // Handshake: ready depends only on registered state, never on inputs
    assign p1_ready   = (state_q == ST_COLLECT) && !p1_captured_q;
    assign p2_ready   = (state_q == ST_COLLECT) && !p2_captured_q;
    assign p1_capture = p1_valid && p1_ready;
    assign p2_capture = p2_valid && p2_ready;

    // A player who never delivered a move plays as "invalid" and forfeits
    assign p1_effective = p1_captured_q ? p1_move_q : MOVE_INVALID;
    assign p2_effective = p2_captured_q ? p2_move_q : MOVE_INVALID;

    rps_judge u_judge (
        .p1_move (p1_effective),
        .p2_move (p2_effective),
        .winner  (judge_winner)
    );

    // Next-state and datapath update logic
    always_comb begin
        state_d        = state_q;
        p1_captured_d  = p1_captured_q;
        p2_captured_d  = p2_captured_q;
        p1_move_d      = p1_move_q;
        p2_move_d      = p2_move_q;
        timer_d        = timer_q;
        p1_score_d     = p1_score_q;
        p2_score_d     = p2_score_q;
        round_count_d  = round_count_q;
        round_winner_d = round_winner_q;
        match_winner_d = match_winner_q;

        case (state_q)
            ST_IDLE: begin
                // abort held in IDLE keeps a new match from starting
                if (start && !abort) begin
                    p1_score_d     = '0;
                    p2_score_d     = '0;
                    round_count_d  = '0;
                    match_winner_d = WIN_NONE;
                    p1_captured_d  = 1'b0;
                    p2_captured_d  = 1'b0;
                    timer_d        = '0;
                    state_d        = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                timer_d = timer_q + 8'd1;
                if (p1_capture) begin
                    p1_captured_d = 1'b1;
                    p1_move_d     = p1_move;
                end
                if (p2_capture) begin
                    p2_captured_d = 1'b1;
                    p2_move_d     = p2_move;
                end
                // Uses the updated flags so a capture on this edge counts
                if ((p1_captured_d && p2_captured_d) || (timer_q == TIMER_LAST)) begin
                    state_d = ST_JUDGE;
                end
            end

            ST_JUDGE: begin
                round_winner_d = judge_winner;
                if (judge_winner == WIN_P1) begin
                    p1_score_d = p1_score_q + 3'd1;
                end else if (judge_winner == WIN_P2) begin
                    p2_score_d = p2_score_q + 3'd1;
                end
                if (round_count_q != 8'hFF) begin
                    round_count_d = round_count_q + 8'd1;
                end
                state_d = ST_REPORT;
            end

            ST_REPORT: begin
                if (p1_score_q == TARGET) begin
                    match_winner_d = WIN_P1;
                    state_d        = ST_MATCH_OVER;
                end else if (p2_score_q == TARGET) begin
                    match_winner_d = WIN_P2;
                    state_d        = ST_MATCH_OVER;
                end else begin
                    p1_captured_d = 1'b0;
                    p2_captured_d = 1'b0;
                    timer_d       = '0;
                    state_d       = ST_COLLECT;
                end
            end

            ST_MATCH_OVER: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything above: the round in flight is dropped
        // without touching the score, and the match result is withdrawn.
        if (abort && (state_q != ST_IDLE)) begin
            state_d        = ST_IDLE;
            p1_captured_d  = 1'b0;
            p2_captured_d  = 1'b0;
            p1_score_d     = p1_score_q;
            p2_score_d     = p2_score_q;
            round_count_d  = round_count_q;
            round_winner_d = round_winner_q;
            match_winner_d = WIN_NONE;
        end
    end

    // State register
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_captured_q  <= 1'b0;
            p2_captured_q  <= 1'b0;
            p1_move_q      <= MOVE_ROCK;
            p2_move_q      <= MOVE_ROCK;
            timer_q        <= '0;
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            round_count_q  <= '0;
            round_winner_q <= WIN_TIE;
            match_winner_q <= WIN_NONE;
        end else begin
            p1_captured_q  <= p1_captured_d;
            p2_captured_q  <= p2_captured_d;
            p1_move_q      <= p1_move_d;
            p2_move_q      <= p2_move_d;
            timer_q        <= timer_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            round_count_q  <= round_count_d;
            round_winner_q <= round_winner_d;
            match_winner_q <= match_winner_d;
        end
    end

    assign round_winner = round_winner_q;
    assign round_done   = (state_q == ST_REPORT);
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign round_count  = round_count_q;
    assign match_done   = (state_q == ST_MATCH_OVER);
    assign match_winner = match_winner_q;
    assign state        = state_q;

endmodule

// File: tb/tb_rps_match_controller.sv
// ---------------------------------------------------------------------------
// tb_rps_match_controller
// Directed bench for rps_match_controller with TARGET_WINS=2 and
// TIMEOUT_CYCLES=4. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_rps_match_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       p1_valid;
    logic       p2_valid;
    logic [1:0] p1_move;
    logic [1:0] p2_move;
    logic       p1_ready;
    logic       p2_ready;
    logic [1:0] round_winner;
    logic       round_done;
    logic [2:0] p1_score;
    logic [2:0] p2_score;
    logic [7:0] round_count;
    logic       match_done;
    logic [1:0] match_winner;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    rps_match_controller #(
        .TARGET_WINS    (2),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .p1_valid     (p1_valid),
        .p2_valid     (p2_valid),
        .p1_move      (p1_move),
        .p2_move      (p2_move),
        .p1_ready     (p1_ready),
        .p2_ready     (p2_ready),
        .round_winner (round_winner),
        .round_done   (round_done),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .round_count  (round_count),
        .match_done   (match_done),
        .match_winner (match_winner),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic offer(input logic v1, input logic [1:0] m1, input logic v2, input logic [1:0] m2);
        p1_valid = v1;
        p1_move  = m1;
        p2_valid = v2;
        p2_move  = m2;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        tick();

        // ---- reset state ----
        check("rst_state",        8'(state),        8'h0);
        check("rst_p1_ready",     8'(p1_ready),     8'h0);
        check("rst_p2_ready",     8'(p2_ready),     8'h0);
        check("rst_round_done",   8'(round_done),   8'h0);
        check("rst_match_done",   8'(match_done),   8'h0);
        check("rst_p1_score",     8'(p1_score),     8'h0);
        check("rst_p2_score",     8'(p2_score),     8'h0);
        check("rst_round_count",  round_count,      8'h0);
        check("rst_round_winner", 8'(round_winner), 8'h0);
        check("rst_match_winner", 8'(match_winner), 8'h0);
        reset = 1'b0;
        tick();
        check("idle_no_start", 8'(state), 8'h0);

        // ---- match A: rock beats scissors, invalid-move rounds ----
        start = 1'b1;
        tick();
        check("A_collect",  8'(state),    8'h1);
        check("A_p1_ready", 8'(p1_ready), 8'h1);
        check("A_p2_ready", 8'(p2_ready), 8'h1);
        start = 1'b0;
        offer(1'b1, 2'b00, 1'b1, 2'b10);
        tick();
        check("A1_judge",      8'(state),      8'h2);
        check("A1_ready_low",  8'(p1_ready),   8'h0);
        check("A1_no_done",    8'(round_done), 8'h0);
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        check("A1_round_done", 8'(round_done),   8'h1);
        check("A1_winner",     8'(round_winner), 8'h1);
        check("A1_p1_score",   8'(p1_score),     8'h1);
        check("A1_p2_score",   8'(p2_score),     8'h0);
        check("A1_count",      round_count,      8'h1);
        tick();
        check("A1_back_collect", 8'(state),      8'h1);
        check("A1_done_pulse",   8'(round_done), 8'h0);
        check("A1_ready_again",  8'(p1_ready),   8'h1);

        // both invalid -> tie, scores unchanged
        offer(1'b1, 2'b11, 1'b1, 2'b11);
        tick();
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        check("A2_winner",   8'(round_winner), 8'h0);
        check("A2_p1_score", 8'(p1_score),     8'h1);
        check("A2_p2_score", 8'(p2_score),     8'h0);
        check("A2_count",    round_count,      8'h2);
        tick();

        // P2 invalid against P1 rock -> P1 wins, reaches target
        offer(1'b1, 2'b00, 1'b1, 2'b11);
        tick();
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        check("A3_winner",     8'(round_winner), 8'h1);
        check("A3_p1_score",   8'(p1_score),     8'h2);
        check("A3_no_mdone",   8'(match_done),   8'h0);
        start = 1'b1;
        tick();
        check("A_match_over",   8'(state),        8'h4);
        check("A_match_done",   8'(match_done),   8'h1);
        check("A_match_winner", 8'(match_winner), 8'h1);
        check("A_over_ready",   8'(p2_ready),     8'h0);
        tick();
        check("A_over_hold",    8'(match_done),   8'h1);
        start = 1'b0;
        tick();
        check("A_release_idle",   8'(state),      8'h0);
        check("A_release_mdone",  8'(match_done), 8'h0);
        check("A_scores_visible", 8'(p1_score),   8'h2);

        // ---- match B: best of 3 with a tie, ignored late move ----
        start = 1'b1;
        tick();
        check("B_clr_p1",    8'(p1_score),     8'h0);
        check("B_clr_count", round_count,      8'h0);
        check("B_clr_mwin",  8'(match_winner), 8'h0);
        start = 1'b0;
        offer(1'b1, 2'b01, 1'b1, 2'b00);
        tick();
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        check("B1_winner", 8'(round_winner), 8'h1);
        tick();
        offer(1'b1, 2'b00, 1'b0, 2'b00);
        tick();
        check("B2_wait_p2",  8'(state),    8'h1);
        check("B2_p1_taken", 8'(p1_ready), 8'h0);
        check("B2_p2_open",  8'(p2_ready), 8'h1);
        offer(1'b1, 2'b10, 1'b1, 2'b00);
        tick();
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        check("B2_tie",      8'(round_winner), 8'h0);
        check("B2_count",    round_count,      8'h2);
        check("B2_p1_score", 8'(p1_score),     8'h1);
        tick();
        offer(1'b1, 2'b10, 1'b1, 2'b01);
        tick();
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        check("B3_winner", 8'(round_winner), 8'h1);
        tick();
        check("B_match_done",   8'(match_done),   8'h1);
        check("B_match_winner", 8'(match_winner), 8'h1);
        check("B_count",        round_count,      8'h3);
        abort = 1'b1;
        tick();
        check("B_abort_idle", 8'(state),        8'h0);
        check("B_abort_mwin", 8'(match_winner), 8'h0);
        abort = 1'b0;

        // ---- match C: timeouts and abort ----
        start = 1'b1;
        tick();
        start = 1'b0;
        offer(1'b1, 2'b01, 1'b0, 2'b00);
        tick();
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        tick();
        check("C1_still_collect", 8'(state), 8'h1);
        tick();
        check("C1_timeout_judge", 8'(state), 8'h2);
        tick();
        check("C1_winner",   8'(round_winner), 8'h1);
        check("C1_p1_score", 8'(p1_score),     8'h1);
        tick();
        tick();
        tick();
        tick();
        check("C2_still_collect", 8'(state), 8'h1);
        tick();
        check("C2_timeout_judge", 8'(state), 8'h2);
        tick();
        check("C2_tie",      8'(round_winner), 8'h0);
        check("C2_p1_score", 8'(p1_score),     8'h1);
        check("C2_p2_score", 8'(p2_score),     8'h0);
        check("C2_count",    round_count,      8'h2);
        tick();
        offer(1'b1, 2'b00, 1'b1, 2'b01);
        tick();
        check("C3_judge", 8'(state), 8'h2);
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        abort = 1'b1;
        tick();
        check("C3_abort_idle", 8'(state),        8'h0);
        check("C3_abort_done", 8'(round_done),   8'h0);
        check("C3_abort_mwin", 8'(match_winner), 8'h0);
        start = 1'b1;
        tick();
        check("C_abort_hold1", 8'(state), 8'h0);
        tick();
        check("C_abort_hold2", 8'(state), 8'h0);
        abort = 1'b0;
        tick();
        check("C_restart",       8'(state),   8'h1);
        check("C_restart_count", round_count, 8'h0);
        start = 1'b0;

        // ---- match D: asynchronous reset mid-round ----
        offer(1'b1, 2'b01, 1'b1, 2'b00);
        tick();
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        tick();
        check("D1_p1_score", 8'(p1_score), 8'h1);
        tick();
        offer(1'b1, 2'b00, 1'b0, 2'b00);
        tick();
        check("D2_p1_taken", 8'(p1_ready), 8'h0);
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        check("D_async_state",  8'(state),        8'h0);
        check("D_async_p1rdy",  8'(p1_ready),     8'h0);
        check("D_async_p2rdy",  8'(p2_ready),     8'h0);
        check("D_async_score",  8'(p1_score),     8'h0);
        check("D_async_count",  round_count,      8'h0);
        check("D_async_rwin",   8'(round_winner), 8'h0);
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        check("D_fresh_p1_ready", 8'(p1_ready), 8'h1);
        start = 1'b0;
        offer(1'b0, 2'b00, 1'b1, 2'b10);
        tick();
        offer(1'b0, 2'b00, 1'b0, 2'b00);
        check("D_p1_still_open", 8'(p1_ready), 8'h1);
        check("D_p2_taken",      8'(p2_ready), 8'h0);
        tick();
        tick();
        tick();
        check("D_timeout_judge", 8'(state), 8'h2);
        tick();
        check("D_winner",    8'(round_winner), 8'h2);
        check("D_p2_score",  8'(p2_score),     8'h1);
        check("D_p1_score",  8'(p1_score),     8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
